// File: rtl/multicycle_sequencer_if.sv
// Memory handshake bundle between the sequencer and the instruction/data memories.
// The sequencer is the master: it raises requests and the memories answer with acks.
interface multicycle_sequencer_if;
  logic imem_req;
  logic imem_ack;
  logic dr;
  logic dw;
  logic dmem_ack;

  modport master (
    output imem_req,
    output dr,
    output dw,
    input  imem_ack,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    input  dr,
    input  dw,
    output imem_ack,
    output dmem_ack
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle MIPS control FSM: fetch, decode, execute, memory, writeback.
// Moore strobes from state; ir_we/pc_we/retire are pulses qualified by ack/zero.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             R,
  input  logic             run,
  input  logic [0:31]      instr,
  input  logic             alu_zero,
  multicycle_sequencer_if.master mem,
  output logic             ir_we,
  output logic             pc_we,
  output logic [0:1]       pc_src,
  output logic             W,
  output logic             S1,
  output logic             S2,
  output logic             S3,
  output logic [0:1]       Aluop,
  output logic             busy,
  output logic             trap,
  output logic             trap_cause,
  output logic [CNT_W-1:0] retired
);

  localparam logic [5:0] OP_R   = 6'd0;
  localparam logic [5:0] OP_J   = 6'd2;
  localparam logic [5:0] OP_BEQ = 6'd4;
  localparam logic [5:0] OP_LW  = 6'd35;
  localparam logic [5:0] OP_SW  = 6'd43;

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } state_t;

  state_t          state;
  state_t          nxt;
  logic [5:0]      op;
  logic [5:0]      op_q;
  logic [WC_W-1:0] wcnt;
  logic            retire;
  logic            trap_set;
  logic            trap_why;
  logic            instr_unused;

  assign op           = instr[26:31];
  assign instr_unused = ^instr[0:25];

  logic d_j;
  logic d_legal;
  assign d_j     = (op == OP_J);
  assign d_legal = (op == OP_R) || (op == OP_BEQ) ||
                   (op == OP_LW) || (op == OP_SW);

  logic x_r;
  logic x_mem;
  logic x_beq;
  assign x_r   = (op_q == OP_R);
  assign x_mem = (op_q == OP_LW) || (op_q == OP_SW);
  assign x_beq = (op_q == OP_BEQ);

  assign busy = (state != IDLE);
  assign trap = (state == TRAP);

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state      <= IDLE;
      op_q       <= '0;
      wcnt       <= '0;
      trap_cause <= 1'b0;
      retired    <= '0;
    end else begin
      state <= nxt;
      if (state == DECODE)
        op_q <= op;
      // Outside MEM the counter sits at zero, so every MEM entry starts fresh.
      if (state == MEM)
        wcnt <= wcnt + 1'b1;
      else
        wcnt <= '0;
      if (trap_set)
        trap_cause <= trap_why;
      if (retire)
        retired <= retired + 1'b1;
    end
  end

  always_comb begin
    nxt          = state;
    mem.imem_req = 1'b0;
    mem.dr       = 1'b0;
    mem.dw       = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'b00;
    W            = 1'b0;
    S1           = 1'b0;
    S2           = 1'b0;
    S3           = 1'b0;
    Aluop        = 2'b00;
    retire       = 1'b0;
    trap_set     = 1'b0;
    trap_why     = 1'b0;
    case (state)
      IDLE: begin
        if (run)
          nxt = FETCH;
      end
      FETCH: begin
        mem.imem_req = 1'b1;
        if (mem.imem_ack) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
          nxt   = DECODE;
        end
      end
      DECODE: begin
        unique case (1'b1)
          d_j: begin
            pc_we  = 1'b1;
            pc_src = 2'b10;
            retire = 1'b1;
            nxt    = run ? FETCH : IDLE;
          end
          d_legal: nxt = EXEC;
          default: begin
            nxt      = TRAP;
            trap_set = 1'b1;
            trap_why = 1'b0;
          end
        endcase
      end
      EXEC: begin
        unique case (1'b1)
          x_r: begin
            Aluop = 2'b10;
            nxt   = WB;
          end
          x_mem: begin
            S2  = 1'b1;
            nxt = MEM;
          end
          x_beq: begin
            Aluop  = 2'b01;
            pc_src = 2'b01;
            pc_we  = alu_zero;
            retire = 1'b1;
            nxt    = run ? FETCH : IDLE;
          end
          default: begin
            nxt      = TRAP;
            trap_set = 1'b1;
            trap_why = 1'b0;
          end
        endcase
      end
      MEM: begin
        S2     = 1'b1;
        mem.dr = (op_q == OP_LW);
        mem.dw = (op_q == OP_SW);
        // An ack arriving on the last allowed cycle still beats the timeout.
        if (mem.dmem_ack) begin
          if (op_q == OP_LW) begin
            nxt = WB;
          end else begin
            retire = 1'b1;
            nxt    = run ? FETCH : IDLE;
          end
        end else if (wcnt == WC_LAST) begin
          nxt      = TRAP;
          trap_set = 1'b1;
          trap_why = 1'b1;
        end
      end
      WB: begin
        W      = 1'b1;
        S1     = (op_q == OP_R);
        S3     = (op_q == OP_LW);
        retire = 1'b1;
        nxt    = run ? FETCH : IDLE;
      end
      TRAP: nxt = TRAP;
      default: nxt = IDLE;
    endcase
  end

endmodule
